// File: rtl/dot_product_pkg.sv
// Shared constants and arithmetic helpers for the dot-product pipeline.
// lat()        : end-to-end latency for a given operand count.
// add_levels() : number of registered adder-tree levels.
// sat_add/mul  : saturating add/multiply clamped to 2^w-1. Operands are passed
//                zero-extended to 64 bits, so widths up to 32 are supported.
package dot_product_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    function automatic int unsigned lat(input int unsigned num_inputs);
        return 32'(1 + $clog2(num_inputs));
    endfunction

    function automatic int unsigned add_levels(input int unsigned num_inputs);
        return 32'($clog2(num_inputs / 2));
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [64:0] max;
        s   = {1'b0, a} + {1'b0, b};
        max = (65'd1 << w) - 65'd1;
        return 64'((s > max) ? max : s);
    endfunction

    function automatic logic [63:0] sat_mul(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [127:0] p;
        logic [127:0] max;
        p   = {64'd0, a} * {64'd0, b};
        max = (128'd1 << w) - 128'd1;
        return 64'((p > max) ? max : p);
    endfunction

endpackage

// File: rtl/dot_product_add_level.sv
// One registered level of the dot-product adder tree: NUM_IN operands reduce
// pairwise to NUM_IN/2 sums. Loads only when i_en (pipeline advance).
// Ports: clk, rst_n (async active-low), i_en, i_valid, i_data -> o_valid, o_data.
// Build option: DOT_PRODUCT_PIPELINE_SAT_EN selects saturating adds.
module dot_product_add_level
    import dot_product_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_en,
    input  logic                              i_valid,
    input  logic [NUM_IN-1:0][WIDTH-1:0]      i_data,
    output logic                              o_valid,
    output logic [NUM_IN/2-1:0][WIDTH-1:0]    o_data
);

    localparam int unsigned NUM_OUT = NUM_IN / 2;

    logic [NUM_OUT-1:0][WIDTH-1:0] w_sum;
    logic [NUM_OUT-1:0][WIDTH-1:0] r_sum;
    logic                          r_valid;

    // Pairwise sums of adjacent operands
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
`ifdef DOT_PRODUCT_PIPELINE_SAT_EN
            w_sum[i] = WIDTH'(sat_add(64'(i_data[2*i]), 64'(i_data[2*i+1]), WIDTH));
`else
            w_sum[i] = i_data[2*i] + i_data[2*i+1];
`endif
        end
    end

    // Stage register; bubbles keep their previous data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sum <= w_sum;
            end
        end
    end

    assign o_data  = r_sum;
    assign o_valid = r_valid;

endmodule

// File: rtl/dot_product_pipeline.sv
// Fully pipelined dot product: out = sum(in[2i]*in[2i+1]), one result per
// cycle when unstalled. Stages: input regs, multipliers, adder-tree levels;
// the last level register drives out. Whole pipe stalls when the output
// holds a result the sink does not take.
// Ports: clk, rst_n (async active-low), in/in_valid/in_ready (source side),
//        out/out_valid/out_ready (sink side). in_ready is combinational.
// Build option: DOT_PRODUCT_PIPELINE_SAT_EN saturates every multiply and add
// to 2^WIDTH-1; otherwise arithmetic wraps mod 2^WIDTH.
module dot_product_pipeline
    import dot_product_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUM_INPUTS = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    in,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [WIDTH-1:0]                    out,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int unsigned LATENCY    = lat(NUM_INPUTS);
    localparam int unsigned NUM_PROD   = NUM_INPUTS / 2;
    localparam int unsigned NUM_LEVELS = LATENCY - 2;
    // Every tree node (products plus all partial sums) in one flat array;
    // level k starts at 2*NUM_PROD - 2*(NUM_PROD>>k), the root is the last.
    localparam int unsigned NUM_NODES  = 2 * NUM_PROD - 1;

    logic                               w_adv;
    logic [NUM_INPUTS-1:0][WIDTH-1:0]   r_in;
    logic                               r_in_valid;
    logic [NUM_PROD-1:0][WIDTH-1:0]     w_prod;
    logic [NUM_PROD-1:0][WIDTH-1:0]     r_prod;
    logic                               r_prod_valid;
    logic [NUM_NODES-1:0][WIDTH-1:0]    w_node;
    logic [NUM_LEVELS:0]                w_vld;

    // Pipeline moves unless a result is waiting on an unready sink
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Input stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in       <= '0;
            r_in_valid <= 1'b0;
        end else if (w_adv) begin
            r_in_valid <= in_valid;
            if (in_valid) begin
                r_in <= in;
            end
        end
    end

    // Multipliers
    always_comb begin
        w_prod = '0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
`ifdef DOT_PRODUCT_PIPELINE_SAT_EN
            w_prod[i] = WIDTH'(sat_mul(64'(r_in[2*i]), 64'(r_in[2*i+1]), WIDTH));
`else
            w_prod[i] = r_in[2*i] * r_in[2*i+1];
`endif
        end
    end

    // Product stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
        end else if (w_adv) begin
            r_prod_valid <= r_in_valid;
            if (r_in_valid) begin
                r_prod <= w_prod;
            end
        end
    end

    assign w_node[NUM_PROD-1:0] = r_prod;
    assign w_vld[0]             = r_prod_valid;

    // Adder-tree levels
    for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_lvl
        localparam int unsigned N_IN    = NUM_PROD >> k;
        localparam int unsigned OFF_IN  = 2 * NUM_PROD - 2 * N_IN;
        localparam int unsigned OFF_OUT = OFF_IN + N_IN;

        dot_product_add_level #(
            .WIDTH  (WIDTH),
            .NUM_IN (N_IN)
        ) u_lvl (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_adv),
            .i_valid (w_vld[k]),
            .i_data  (w_node[OFF_IN+N_IN-1:OFF_IN]),
            .o_valid (w_vld[k+1]),
            .o_data  (w_node[OFF_OUT+N_IN/2-1:OFF_OUT])
        );
    end

    assign out       = w_node[NUM_NODES-1];
    assign out_valid = w_vld[NUM_LEVELS];

endmodule

// File: tb/tb_dot_product_pipeline.sv
// Bench for dot_product_pipeline: three instances (2, 8, 16 operands), one
// exercised at a time against a queue-based reference model. Each accepted
// vector is tracked with the number of pipeline advances it has seen and
// becomes visible at the output after LATENCY-1 advances.
module tb_dot_product_pipeline;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;

    logic [1:0][W-1:0]  in2;
    logic [7:0][W-1:0]  in8;
    logic [15:0][W-1:0] in16;
    logic v2, v8, v16, ir2, ir8, ir16, ov2, ov8, ov16, or2, or8, or16;
    logic [W-1:0] o2, o8, o16;

    dot_product_pipeline #(.WIDTH(W), .NUM_INPUTS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in(in2), .in_valid(v2), .in_ready(ir2),
        .out(o2), .out_valid(ov2), .out_ready(or2));

    dot_product_pipeline #(.WIDTH(W), .NUM_INPUTS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .in_valid(v8), .in_ready(ir8),
        .out(o8), .out_valid(ov8), .out_ready(or8));

    dot_product_pipeline #(.WIDTH(W), .NUM_INPUTS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in(in16), .in_valid(v16), .in_ready(ir16),
        .out(o16), .out_valid(ov16), .out_ready(or16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        int           age;
    } item_t;

    item_t        mq[$];
    logic [W-1:0] g_ops [16];
    logic [W-1:0] g_last_out;
    int           g_seen;
    int           g_accepted;
    int           n_checks;
    int           n_errors;

    function automatic logic [W-1:0] ref_dot(input int n);
        longint unsigned acc;
        acc = 0;
        for (int i = 0; i < n / 2; i++) begin
            acc += 64'(g_ops[2*i]) * 64'(g_ops[2*i+1]);
        end
`ifdef DOT_PRODUCT_PIPELINE_SAT_EN
        // Nonnegative operands: any clamp along the tree clamps the result
        return (acc > 64'hFFFF) ? 16'hFFFF : W'(acc);
`else
        return W'(acc);
`endif
    endfunction

    function automatic logic dut_ov(input int d);
        case (d)
            2:       return ov2;
            8:       return ov8;
            default: return ov16;
        endcase
    endfunction

    function automatic logic dut_ir(input int d);
        case (d)
            2:       return ir2;
            8:       return ir8;
            default: return ir16;
        endcase
    endfunction

    function automatic logic [W-1:0] dut_o(input int d);
        case (d)
            2:       return o2;
            8:       return o8;
            default: return o16;
        endcase
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 16; i++) begin
            g_ops[i] = ($urandom_range(0, 5) == 0) ? 16'hFFFF : W'($urandom);
        end
    endtask

    task automatic drive(input int d, input bit v, input bit r);
        v2 = 1'b0; v8 = 1'b0; v16 = 1'b0;
        or2 = 1'b1; or8 = 1'b1; or16 = 1'b1;
        for (int i = 0; i < 2; i++)  in2[i]  = g_ops[i];
        for (int i = 0; i < 8; i++)  in8[i]  = g_ops[i];
        for (int i = 0; i < 16; i++) in16[i] = g_ops[i];
        case (d)
            2:       begin v2  = v; or2  = r; end
            8:       begin v8  = v; or8  = r; end
            default: begin v16 = v; or16 = r; end
        endcase
    endtask

    // One clock of stimulus on instance d, checked against the model.
    // Entered and left just after a falling edge.
    task automatic cycle(input int d, input bit v, input bit r);
        int    lat;
        bit    mv;
        bit    adv;
        item_t it;
        lat = 1 + $clog2(d);
        drive(d, v, r);
        #1;
        mv = (mq.size() > 0) && (mq[0].age == lat - 1);
        n_checks++;
        if (dut_ov(d) !== mv) begin
            n_errors++;
            $display("FAIL out_valid n=%0d t=%0t: got %b expected %b", d, $time, dut_ov(d), mv);
        end
        if (mv) begin
            n_checks++;
            if (dut_o(d) !== mq[0].val) begin
                n_errors++;
                $display("FAIL out_data n=%0d t=%0t: got %h expected %h", d, $time, dut_o(d), mq[0].val);
            end
            g_last_out = dut_o(d);
        end
        n_checks++;
        if (dut_ir(d) !== (!mv || r)) begin
            n_errors++;
            $display("FAIL in_ready n=%0d t=%0t: got %b expected %b", d, $time, dut_ir(d), !mv || r);
        end
        if (dut_ov(d) === 1'b1 && r) g_seen++;
        @(posedge clk);
        adv = !mv || r;
        if (adv) begin
            if (mv) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age = mq[i].age + 1;
            if (v) begin
                it.val = ref_dot(d);
                it.age = 0;
                mq.push_back(it);
                g_accepted++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 40 && mq.size() > 0; i++) cycle(d, 1'b0, 1'b1);
        n_checks++;
        if (mq.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout n=%0d: %0d results still pending, expected 0", d, mq.size());
        end
    endtask

    task automatic check_delivered(input string name, input int seen0, input int exp);
        n_checks++;
        if (g_seen - seen0 != exp) begin
            n_errors++;
            $display("FAIL %s: delivered %0d results, expected %0d", name, g_seen - seen0, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        n_checks += 9;
        if (o2 !== '0 || ov2 !== 1'b0 || ir2 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_n2: out=%h out_valid=%b in_ready=%b expected 0/0/1", o2, ov2, ir2);
        end
        if (o8 !== '0 || ov8 !== 1'b0 || ir8 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_n8: out=%h out_valid=%b in_ready=%b expected 0/0/1", o8, ov8, ir8);
        end
        if (o16 !== '0 || ov16 !== 1'b0 || ir16 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_n16: out=%h out_valid=%b in_ready=%b expected 0/0/1", o16, ov16, ir16);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int s0;
        s0 = g_seen;
        for (int i = 0; i < 16; i++) g_ops[i] = W'(i + 1);
        g_last_out = '0;
        cycle(8, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(8, 1'b0, 1'b1);
        n_checks++;
        if (g_last_out !== 16'd100) begin
            n_errors++;
            $display("FAIL single_1to8: got %0d expected 100", g_last_out);
        end
        check_delivered("single_count", s0, 1);
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = g_seen;
        for (int i = 0; i < 20; i++) begin
            rand_ops();
            cycle(8, 1'b1, 1'b1);
        end
        drain(8);
        check_delivered("back_to_back_count", s0, 20);
    endtask

    task automatic test_backpressure();
        int s0;
        int a0;
        s0 = g_seen;
        a0 = g_accepted;
        for (int i = 0; i < 9; i++) begin
            rand_ops();
            cycle(8, 1'b1, 1'b0);
        end
        drain(8);
        // Four vectors fit before the first result blocks the pipe
        n_checks++;
        if (g_accepted - a0 != 4) begin
            n_errors++;
            $display("FAIL stall_accepts: accepted %0d expected 4", g_accepted - a0);
        end
        check_delivered("stall_count", s0, 4);
    endtask

    task automatic test_wrap_sat();
        for (int i = 0; i < 16; i++) g_ops[i] = 16'hFFFF;
        g_last_out = '0;
        cycle(8, 1'b1, 1'b1);
        drain(8);
        n_checks++;
`ifdef DOT_PRODUCT_PIPELINE_SAT_EN
        if (g_last_out !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL all_ones_sat: got %h expected ffff", g_last_out);
        end
`else
        if (g_last_out !== 16'h0004) begin
            n_errors++;
            $display("FAIL all_ones_wrap: got %h expected 0004", g_last_out);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        int s0;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            cycle(8, 1'b1, 1'b1);
        end
        rst_n = 1'b0;
        drive(8, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (o8 !== '0 || ov8 !== 1'b0 || ir8 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_midstream: out=%h out_valid=%b in_ready=%b expected 0/0/1", o8, ov8, ir8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        s0 = g_seen;
        for (int i = 0; i < 8; i++) cycle(8, 1'b0, 1'b1);
        check_delivered("reset_no_stale", s0, 0);
    endtask

    task automatic test_random_sizes();
        int d;
        int s0;
        int a0;
        for (int k = 0; k < 3; k++) begin
            d  = (k == 0) ? 2 : ((k == 1) ? 16 : 8);
            s0 = g_seen;
            a0 = g_accepted;
            for (int i = 0; i < 60; i++) begin
                rand_ops();
                cycle(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            end
            drain(d);
            check_delivered("random_count", s0, g_accepted - a0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        g_seen     = 0;
        g_accepted = 0;
        g_last_out = '0;
        for (int i = 0; i < 16; i++) g_ops[i] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap_sat();
        test_reset_midstream();
        test_random_sizes();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
